// File: rtl/rotate_through_carry_unit_if.sv
// Handshake and operand bus between the EX stage and the rotate-through-carry unit.
interface rotate_through_carry_unit_if;
  logic        start;
  logic        flush;
  logic        EX_de_rot_dir;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  datasize;
  logic        cf_in;
  logic        busy;
  logic        done;
  logic [31:0] rot_result;
  logic [31:0] rot_flags;

  modport master (
    output start, flush, EX_de_rot_dir, a, b, datasize, cf_in,
    input  busy, done, rot_result, rot_flags
  );

  modport slave (
    input  start, flush, EX_de_rot_dir, a, b, datasize, cf_in,
    output busy, done, rot_result, rot_flags
  );
endinterface

// File: rtl/rotate_through_carry_unit.sv
// Iterative RCL/RCR unit: rotates a W-bit operand (W = 8/16/32) through CF
// one bit per clock and returns the result plus an EFLAGS-format flags word.
module rotate_through_carry_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic                        clk,
  input logic                        reset,
  rotate_through_carry_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_DONE
  } state_t;

  state_t              state;
  logic                dir_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   data_q;
  logic                carry_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   result_q;
  logic [31:0]         flags_q;

  logic [4:0]          c5;
  logic [4:0]          eff;
  logic [DATA_W-1:0]   a_masked;
  logic [DATA_W-1:0]   step_data;
  logic                step_carry;
  logic                step_of;
  logic [4:0]          msb_q;
  logic [4:0]          msb_m1;

  // Only the low five count bits and the low operand bits matter.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.b[31:5]};

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = DATA_W'(32'h0000_00FF);
      2'd1:    size_mask = DATA_W'(32'h0000_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [4:0] size_msb(input logic [1:0] size);
    case (size)
      2'd0:    size_msb = 5'd7;
      2'd1:    size_msb = 5'd15;
      default: size_msb = 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] make_flags(input logic of, input logic cf);
    make_flags     = '0;
    make_flags[11] = of;
    make_flags[0]  = cf;
  endfunction

  // Accept-cycle decode: effective count reduced modulo the ring length.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    c5       = bus.b[4:0];
    eff      = c5;
    a_masked = bus.a[DATA_W-1:0] & size_mask(bus.datasize);
    case (bus.datasize)
      2'd0: begin
        if (c5 >= 5'd27)      eff = c5 - 5'd27;
        else if (c5 >= 5'd18) eff = c5 - 5'd18;
        else if (c5 >= 5'd9)  eff = c5 - 5'd9;
      end
      2'd1: begin
        if (c5 >= 5'd17) eff = c5 - 5'd17;
      end
      default: eff = c5;
    endcase
  end

  // One-bit rotate of the (W+1)-bit ring {carry, data} and the OF it implies.
  always_comb begin
    msb_q      = size_msb(size_q);
    msb_m1     = msb_q - 5'd1;
    step_data  = '0;
    step_carry = 1'b0;
    step_of    = 1'b0;
    if (!dir_q) begin
      step_carry = data_q[msb_q];
      step_data  = ((data_q << 1) | DATA_W'(carry_q)) & size_mask(size_q);
      step_of    = step_data[msb_q] ^ step_carry;
    end else begin
      step_carry = data_q[0];
      step_data  = (data_q >> 1) | (DATA_W'(carry_q) << msb_q);
      step_of    = step_data[msb_q] ^ step_data[msb_m1];
    end
  end

  // Control FSM with registered handshake and result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state    <= S_IDLE;
      dir_q    <= 1'b0;
      size_q   <= 2'd0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dir_q   <= bus.EX_de_rot_dir;
            size_q  <= bus.datasize;
            data_q  <= a_masked;
            carry_q <= bus.cf_in;
            cnt_q   <= CNT_W'(eff);
            busy_q  <= 1'b1;
            if (eff == 5'd0) begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              result_q <= a_masked;
              flags_q  <= make_flags(1'b0, bus.cf_in);
            end else begin
              state <= S_ROT;
            end
          end
        end
        S_ROT: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            result_q <= step_data;
            flags_q  <= make_flags(step_of, step_carry);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rot_result = 32'(result_q);
  assign bus.rot_flags  = flags_q;

endmodule
